instruction_loader: RTL and testbench
=====================================

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

Interface
REQ-001 Parameter DEPTH_WORDS, 64, instruction memory capacity in 32-bit words; legal range 1..65535.
REQ-002 Parameter BASE_ADDR, 32'h0, byte address of the first written word; word-aligned.
REQ-003 clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a load.
REQ-006 in_byte  input  8  serial load stream byte.
REQ-007 in_valid  input  1  in_byte is valid.
REQ-008 in_ready  output  1  loader accepts a byte this cycle.
REQ-009 imem_wr_en  output  1  instruction memory write strobe.
REQ-010 imem_addr  output  32  instruction memory byte address.
REQ-011 imem_wr_data  output  32  instruction word to write.
REQ-012 cpu_reset  output  1  active-high reset to the processor.
REQ-013 busy  output  1  load in progress.
REQ-014 done  output  1  load completed successfully.
REQ-015 error  output  1  load aborted.

Function
REQ-016 States IDLE, HDR, DATA, CSUM, DONE, ERROR; registered state, registered outputs.
REQ-017 A byte is accepted only in a cycle with in_valid=1 and in_ready=1; in_ready=1 exactly in HDR, DATA and CSUM.
REQ-018 Every frame field is 32 bits, sent big-endian: first accepted byte lands in bits [31:24].
REQ-019 IDLE/DONE/ERROR with start=1 -> HDR next cycle; word and byte counters and checksum cleared; done and error cleared.
REQ-020 start in HDR, DATA or CSUM is ignored.
REQ-021 HDR: four bytes assemble word count N.
REQ-022 N > DEPTH_WORDS -> ERROR after the fourth header byte; no memory write occurs.
REQ-023 N = 0 -> CSUM if REQ-036 is enabled, else DONE.
REQ-024 Otherwise HDR -> DATA.
REQ-025 DATA: after the fourth byte of word k (k = 0..N-1), imem_wr_en=1 for exactly the next cycle, imem_addr = BASE_ADDR + 4*k, imem_wr_data = assembled word.
REQ-026 Byte acceptance continues in the write cycle; a back-to-back stream loses nothing.
REQ-027 Gaps (in_valid=0) stall assembly without losing partial bytes.
REQ-028 Acceptance of the last byte of word N-1 -> CSUM (checksum enabled) or DONE; the final write strobe still occurs per REQ-025.
REQ-029 imem_wr_en=0 in every cycle other than REQ-025 write cycles; imem_addr and imem_wr_data hold their last values.
REQ-030 busy=1 in HDR, DATA and CSUM only.
REQ-031 done=1 only in DONE; error=1 only in ERROR; both are sticky until start or reset.
REQ-032 cpu_reset=1 in every state except DONE, so the processor runs only from a complete image.
REQ-033 Entry into DONE, and therefore cpu_reset deassertion, occurs no earlier than the cycle after the final write strobe.

Reset
REQ-034 reset=0 at a clock edge -> IDLE; in_ready=0, imem_wr_en=0, imem_addr=0, imem_wr_data=0, busy=0, done=0, error=0, cpu_reset=1, all counters and checksum=0.
REQ-035 Reset mid-load abandons the frame immediately; no write strobe follows; words already written are not revisited.

Configuration
REQ-036 Macro LOADER_CHECKSUM_EN defined: checksum = sum mod 2^32 of the N data words; CSUM accepts four further bytes; match -> DONE; mismatch -> ERROR with cpu_reset held at 1. Macro undefined: the CSUM state and the checksum register are absent, and the frame ends after the data words.

Verification
REQ-037 Reset held 0 for 2 cycles, then released -> IDLE, cpu_reset=1, done=0, error=0, in_ready=0.
REQ-038 start; bytes 00 00 00 02, 24 08 00 05, 01 09 50 20 streamed with no gaps (checksum disabled) -> two strobes, at addr 0 with data 32'h24080005 and at addr 4 with data 32'h01095020; then done=1 and cpu_reset=0.
REQ-039 Same frame with in_valid=0 inserted after every byte -> identical writes and final state; in_ready=1 throughout HDR and DATA.
REQ-040 DEPTH_WORDS=64; header 00 00 00 41 -> error=1 and cpu_reset=1 with zero strobes; a subsequent start with a valid frame succeeds.
REQ-041 With LOADER_CHECKSUM_EN defined: REQ-038 data followed by checksum 25 11 50 25 -> done=1; checksum 25 11 50 26 -> error=1 and cpu_reset=1.
REQ-042 reset=0 after the second data byte of word 1 -> no further strobes; IDLE; a new start with header 00 00 00 00 -> done (checksum disabled).

Source files
------------

// File: rtl/instruction_loader.sv
// instruction_loader
// ------------------
// Receives a serial byte-stream image frame and writes it into instruction
// memory, holding the processor in reset until a complete image is loaded.
//
// Frame layout (every field 32 bits, big-endian, first byte -> [31:24]):
//   header word N (number of data words), N data words,
//   then one checksum word when LOADER_CHECKSUM_EN is defined.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   defined   : a trailing checksum word (sum mod 2^32 of the data words) is
//               required; a mismatch ends the load in ERROR.
//   undefined : no checksum state or register; the frame ends after the data.
//
// Parameters
//   DEPTH_WORDS  instruction memory capacity in 32-bit words (1..65535)
//   BASE_ADDR    byte address of the first written word (word aligned)
//
// Ports
//   clock         in   sole clock, rising edge
//   reset         in   synchronous, active-low
//   start         in   one-cycle load request (honoured in IDLE/DONE/ERROR)
//   in_byte[7:0]  in   stream byte
//   in_valid      in   in_byte is valid
//   in_ready      out  loader can take a byte this cycle
//   imem_wr_en    out  one-cycle instruction memory write strobe
//   imem_addr     out  write byte address (holds between strobes)
//   imem_wr_data  out  write data (holds between strobes)
//   cpu_reset     out  active-high processor reset, low only in DONE
//   busy          out  frame in progress
//   done          out  load completed (sticky until start/reset)
//   error         out  load aborted (sticky until start/reset)
//   dbg_state     out  current FSM state encoding, for observation
//
// Handshake: a byte transfers on a rising edge where in_valid=1 and
// in_ready=1. in_ready is a registered function of the state only; it never
// depends on in_valid, and the sender may hold in_valid low for any number
// of cycles without losing partially assembled bytes.
module instruction_loader #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        imem_wr_en,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wr_data,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM  = 3'd3,
`endif
    S_DONE  = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;   // bytes already taken in current field
  logic [23:0] shift_q, shift_d;         // earlier bytes of current field
  logic [31:0] n_q, n_d;                 // header word count
  logic [31:0] word_cnt_q, word_cnt_d;   // data words completed so far
  logic        wr_en_q, wr_en_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;
  logic        in_ready_q, in_ready_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        cpu_reset_q, cpu_reset_d;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum_q, csum_d;
`endif

  logic        accept;
  logic [31:0] word_full;   // field value if this byte is its fourth

  assign accept    = in_valid && in_ready_q;
  assign word_full = {shift_q, in_byte};

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shift_d    = shift_q;
    n_d        = n_q;
    word_cnt_d = word_cnt_q;
    wr_en_d    = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d    = S_HDR;
          byte_cnt_d = 2'd0;
          shift_d    = 24'd0;
          n_d        = 32'd0;
          word_cnt_d = 32'd0;
`ifdef LOADER_CHECKSUM_EN
          csum_d     = 32'd0;
`endif
        end
      end

      S_HDR: begin
        if (accept) begin
          shift_d    = word_full[23:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            n_d = word_full;
            if (word_full > 32'(DEPTH_WORDS)) begin
              state_d = S_ERROR;
            end else if (word_full == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          shift_d    = word_full[23:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            wr_en_d    = 1'b1;
            addr_d     = BASE_ADDR + (word_cnt_q << 2);
            data_d     = word_full;
            word_cnt_d = word_cnt_q + 32'd1;
`ifdef LOADER_CHECKSUM_EN
            csum_d     = csum_q + word_full;
`endif
            if (word_cnt_q == n_q - 32'd1) begin
`ifdef LOADER_CHECKSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
            end
          end
        end
      end

`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (accept) begin
          shift_d    = word_full[23:0];
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            state_d = (word_full == csum_q) ? S_DONE : S_ERROR;
          end
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_HDR) || (state_d == S_DATA)
`ifdef LOADER_CHECKSUM_EN
                 || (state_d == S_CSUM)
`endif
                 ;
    busy_d     = in_ready_d;
    error_d    = (state_d == S_ERROR);
    // The final write strobe is registered on the same edge that enters
    // DONE, so done (and the cpu_reset release) waits until the state has
    // been DONE for a full cycle: the processor is never released in the
    // cycle that still carries the last memory write.
    done_d      = (state_d == S_DONE) && (state_q == S_DONE);
    cpu_reset_d = !done_d;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= 2'd0;
      shift_q     <= 24'd0;
      n_q         <= 32'd0;
      word_cnt_q  <= 32'd0;
      wr_en_q     <= 1'b0;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      cpu_reset_q <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      shift_q     <= shift_d;
      n_q         <= n_d;
      word_cnt_q  <= word_cnt_d;
      wr_en_q     <= wr_en_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      cpu_reset_q <= cpu_reset_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign in_ready     = in_ready_q;
  assign imem_wr_en   = wr_en_q;
  assign imem_addr    = addr_q;
  assign imem_wr_data = data_q;
  assign cpu_reset    = cpu_reset_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_instruction_loader.sv
// Testbench for instruction_loader: directed frames plus randomized frames,
// checked against a frame-level reference model (expected write list and
// expected final outcome computed from the frame contents).
module tb_instruction_loader;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h0;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        start = 1'b0;
  logic [7:0]  in_byte = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready, imem_wr_en, cpu_reset, busy, done, error;
  logic [31:0] imem_addr, imem_wr_data;
  logic [2:0]  dbg_state;

  instruction_loader #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_byte(in_byte), .in_valid(in_valid), .in_ready(in_ready),
    .imem_wr_en(imem_wr_en), .imem_addr(imem_addr), .imem_wr_data(imem_wr_data),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error),
    .dbg_state(dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // scoreboard state
  logic [63:0] exp_q[$];     // {addr, data} expected writes for a frame
  logic [63:0] act_q[$];     // every observed write
  logic [7:0]  frame_q[$];   // bytes to send
  logic [31:0] word_q[$];    // data words of the frame
  bit          exp_ok;

  // monitor
  int cyc = 0;
  int last_wr_cyc = -1;
  int done_cyc = -1;
  logic done_prev = 1'b0;
  always @(posedge clock) cyc++;
  always @(negedge clock) begin
    if (imem_wr_en === 1'b1) begin
      act_q.push_back({imem_addr, imem_wr_data});
      last_wr_cyc = cyc;
    end
    if (done === 1'b1 && done_prev !== 1'b1) done_cyc = cyc;
    done_prev = done;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: builds the byte frame, the expected writes and outcome
  task automatic build_frame(input logic [31:0] n, input bit bad_csum);
    logic [31:0] sum, c, w;
    frame_q.delete();
    exp_q.delete();
    for (int s = 3; s >= 0; s--) frame_q.push_back(n[8*s +: 8]);
    if (n > DEPTH) begin
      exp_ok = 1'b0;
      return;
    end
    sum = 32'd0;
    for (int k = 0; k < int'(n); k++) begin
      w = word_q[k];
      for (int s = 3; s >= 0; s--) frame_q.push_back(w[8*s +: 8]);
      exp_q.push_back({BASE + 32'(4 * k), w});
      sum = sum + w;
    end
`ifdef LOADER_CHECKSUM_EN
    c = bad_csum ? (sum ^ (32'd1 << $urandom_range(31, 0))) : sum;
    for (int s = 3; s >= 0; s--) frame_q.push_back(c[8*s +: 8]);
    exp_ok = !bad_csum;
`else
    c = sum;
    exp_ok = 1'b1;
`endif
  endtask

  // drivers (called at a negedge, return at a negedge)
  task automatic do_reset(input int cycles);
    reset = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    repeat (cycles) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("start_in_ready", in_ready, 1);
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_error", error, 0);
    chk("start_cpu_reset", cpu_reset, 1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      @(negedge clock);
      chk("gap_in_ready", in_ready, 1);
    end
    in_byte  = b;
    in_valid = 1'b1;
    start    = with_start;
    chk("byte_in_ready", in_ready, 1);
    @(negedge clock);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int gap_lo, input int gap_hi,
                           input bit glitch);
    int  base;
    bit  ended;
    base = act_q.size();
    pulse_start();
    foreach (frame_q[i])
      send_byte(frame_q[i], int'($urandom_range(gap_hi, gap_lo)), glitch && (i == 5));
    ended = 1'b0;
    for (int c = 0; c < 20 && !ended; c++) begin
      @(negedge clock);
      ended = (done === 1'b1) || (error === 1'b1);
    end
    @(negedge clock);
    chk({tag, "_ended"}, ended, 1);
    chk({tag, "_done"}, done, exp_ok);
    chk({tag, "_error"}, error, !exp_ok);
    chk({tag, "_cpu_reset"}, cpu_reset, !exp_ok);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_wr_en_idle"}, imem_wr_en, 0);
    chk({tag, "_nwrites"}, act_q.size() - base, exp_q.size());
    for (int k = 0; k < exp_q.size() && base + k < act_q.size(); k++)
      chk({tag, "_write"}, act_q[base + k], exp_q[k]);
    if (exp_ok && exp_q.size() > 0)
      chk({tag, "_done_after_strobe"}, done_cyc > last_wr_cyc, 1);
  endtask

  initial begin
    int n, base;
    bit badc;

    // reset held low for two cycles
    @(negedge clock);
    do_reset(2);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_wr_en", imem_wr_en, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_data", imem_wr_data, 0);

    // two-word frame, back to back
    word_q = '{32'h24080005, 32'h01095020};
    build_frame(2, 1'b0);
    run_frame("b2b", 0, 0, 1'b0);

    // same frame with a one-cycle gap before every byte
    build_frame(2, 1'b0);
    run_frame("gaps", 1, 1, 1'b0);

`ifdef LOADER_CHECKSUM_EN
    // explicit checksum values 25115025 (good) and 25115026 (bad)
    build_frame(2, 1'b0);
    chk("model_csum", {frame_q[12], frame_q[13], frame_q[14], frame_q[15]}, 32'h25115025);
    run_frame("csum_good", 0, 0, 1'b0);
    build_frame(2, 1'b0);
    frame_q[15] = 8'h26;
    exp_ok = 1'b0;
    run_frame("csum_bad", 0, 0, 1'b0);
`endif

    // header one over capacity, then a valid frame
    build_frame(DEPTH + 1, 1'b0);
    run_frame("over", 0, 0, 1'b0);
    build_frame(32'hFFFF_FFFF, 1'b0);
    run_frame("over_max", 0, 1, 1'b0);
    build_frame(2, 1'b0);
    run_frame("after_err", 0, 0, 1'b0);

    // exactly at capacity
    word_q.delete();
    for (int k = 0; k < DEPTH; k++) word_q.push_back($urandom);
    build_frame(DEPTH, 1'b0);
    run_frame("full", 0, 1, 1'b0);

    // reset after the second byte of word 1
    word_q = '{32'h24080005, 32'h01095020};
    build_frame(2, 1'b0);
    base = act_q.size();
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(frame_q[i], 0, 1'b0);
    do_reset(1);
    @(negedge clock);
    chk("midrst_first_write", act_q.size() - base, 1);
    base = act_q.size();
    repeat (6) @(negedge clock);
    chk("midrst_no_strobe", act_q.size() - base, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_cpu_reset", cpu_reset, 1);
    chk("midrst_addr", imem_addr, 0);
    chk("midrst_data", imem_wr_data, 0);
    word_q.delete();
    build_frame(0, 1'b0);
    run_frame("empty", 0, 0, 1'b0);

    // randomized frames
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(9, 0))
        0:       n = DEPTH + 1 + int'($urandom_range(100, 0));
        1:       n = 0;
        default: n = int'($urandom_range(6, 1));
      endcase
      word_q.delete();
      for (int k = 0; k < n && k < DEPTH; k++) word_q.push_back($urandom);
`ifdef LOADER_CHECKSUM_EN
      badc = ($urandom_range(3, 0) == 0);
`else
      badc = 1'b0;
`endif
      build_frame(32'(n), badc);
      run_frame("rand", 0, 2, $urandom_range(1, 0) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
